// File: rtl/fetch_sequencer.sv
// Fetch sequencer: owns the architectural PC, keeps at most one instruction-memory
// request outstanding, holds the fetched word for IF/ID and applies branch/jump redirects.
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC   = 32'h0000_3000,
    parameter int unsigned WAIT_LIMIT = 255,
    parameter int unsigned CNT_W      = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc4,
    output logic        fetch_err
);

    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_HOLD,
        S_ERR
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_LIMIT - 1);

    state_t             state_q, state_d;
    logic [31:0]        pc_q, pc_d;
    logic [31:0]        pending_q, pending_d;
    logic               squash_q, squash_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               started_q;
    logic               if_valid_q, if_valid_d;
    logic [31:0]        if_instr_q, if_instr_d;
    logic [31:0]        if_pc_q, if_pc_d;
    logic [31:0]        if_pc4_q, if_pc4_d;
    logic               err_q, err_d;

    logic               misalign;
    logic               req_live;

    // started_q keeps imem_req low until the first edge after reset release.
    assign req_live  = started_q && (state_q == S_REQ);
    assign misalign  = redirect_valid && (redirect_pc[1:0] != 2'b00);

    assign imem_req  = req_live;
    assign imem_addr = pc_q;
    assign if_valid  = if_valid_q;
    assign if_instr  = if_instr_q;
    assign if_pc     = if_pc_q;
    assign if_pc4    = if_pc4_q;
    assign fetch_err = err_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_REQ;
            pc_q       <= RESET_PC;
            pending_q  <= '0;
            squash_q   <= 1'b0;
            cnt_q      <= '0;
            started_q  <= 1'b0;
            if_valid_q <= 1'b0;
            if_instr_q <= '0;
            if_pc_q    <= '0;
            if_pc4_q   <= 32'd4;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pending_q  <= pending_d;
            squash_q   <= squash_d;
            cnt_q      <= cnt_d;
            started_q  <= 1'b1;
            if_valid_q <= if_valid_d;
            if_instr_q <= if_instr_d;
            if_pc_q    <= if_pc_d;
            if_pc4_q   <= if_pc4_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        pending_d  = pending_q;
        squash_d   = squash_q;
        cnt_d      = cnt_q;
        if_valid_d = if_valid_q;
        if_instr_d = if_instr_q;
        if_pc_d    = if_pc_q;
        if_pc4_d   = if_pc4_q;
        err_d      = err_q;

        if (misalign) begin
            state_d    = S_ERR;
            if_valid_d = 1'b0;
            err_d      = 1'b1;
        end else begin
            case (state_q)
                S_REQ: begin
                    if (req_live && imem_gnt) begin
                        state_d = S_WAIT;
                        cnt_d   = '0;
                        if (redirect_valid) begin
                            squash_d  = 1'b1;
                            pending_d = redirect_pc;
                        end
                    end else if (redirect_valid) begin
                        pc_d = redirect_pc;
                    end
                end

                S_WAIT: begin
                    cnt_d = cnt_q + 1'b1;
                    if (imem_rvalid) begin
                        if (squash_q || redirect_valid) begin
                            // Stale response: drop it and restart at the newest target.
                            pc_d     = redirect_valid ? redirect_pc : pending_q;
                            squash_d = 1'b0;
                            state_d  = S_REQ;
                        end else begin
                            if_instr_d = imem_rdata;
                            if_pc_d    = pc_q;
                            if_pc4_d   = pc_q + 32'd4;
                            if_valid_d = 1'b1;
                            state_d    = S_HOLD;
                        end
                    end else begin
                        if (redirect_valid) begin
                            squash_d  = 1'b1;
                            pending_d = redirect_pc;
                        end
                        if (cnt_q == CNT_LAST) begin
                            state_d = S_ERR;
                            err_d   = 1'b1;
                        end
                    end
                end

                S_HOLD: begin
                    if (redirect_valid) begin
                        if_valid_d = 1'b0;
                        pc_d       = redirect_pc;
                        state_d    = S_REQ;
                    end else if (!stall) begin
                        if_valid_d = 1'b0;
                        pc_d       = if_pc4_q;
                        state_d    = S_REQ;
                    end
                end

                S_ERR: begin
                    if_valid_d = 1'b0;
                    err_d      = 1'b1;
                end

                default: begin
                    state_d = S_ERR;
                    err_d   = 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: hand-timed IM handshakes with inline expected values.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [31:0] if_pc4;
    logic        fetch_err;

    int n_checks = 0;
    int n_fail   = 0;

    fetch_sequencer #(
        .RESET_PC  (32'h0000_3000),
        .WAIT_LIMIT(255),
        .CNT_W     (8)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_gnt      (imem_gnt),
        .imem_rvalid   (imem_rvalid),
        .imem_rdata    (imem_rdata),
        .if_valid      (if_valid),
        .if_instr      (if_instr),
        .if_pc         (if_pc),
        .if_pc4        (if_pc4),
        .fetch_err     (fetch_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish, got running want finished");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Holds reset for two edges and releases it 1 time unit after an edge.
    task automatic apply_reset();
        reset          = 1'b1;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        imem_gnt       = 1'b0;
        imem_rvalid    = 1'b0;
        imem_rdata     = '0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        reset = 1'b1;
        #1;
        n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL rst_req: got %b want 0", imem_req); end
        n_checks++; if (imem_addr !== 32'h3000) begin n_fail++; $display("FAIL rst_addr: got %h want 00003000", imem_addr); end
        n_checks++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL rst_if_valid: got %b want 0", if_valid); end
        n_checks++; if (if_instr !== 32'h0) begin n_fail++; $display("FAIL rst_if_instr: got %h want 0", if_instr); end
        n_checks++; if (if_pc !== 32'h0) begin n_fail++; $display("FAIL rst_if_pc: got %h want 0", if_pc); end
        n_checks++; if (if_pc4 !== 32'h4) begin n_fail++; $display("FAIL rst_if_pc4: got %h want 4", if_pc4); end
        n_checks++; if (fetch_err !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %b want 0", fetch_err); end
        reset = 1'b0;
        #1;
        n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL rst_req_before_edge: got %b want 0", imem_req); end
        tick();
        n_checks++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL rst_req_after_edge: got %b want 1", imem_req); end
    endtask

    task automatic test_sequential();
        logic [31:0] exp_pc;
        logic [31:0] word;
        apply_reset();
        tick();
        for (int unsigned i = 0; i < 3; i++) begin
            exp_pc = 32'h3000 + 32'(4 * i);
            word   = 32'hA000_0000 + 32'(i);
            n_checks++; if (imem_req !== 1'b1 || imem_addr !== exp_pc) begin n_fail++; $display("FAIL seq_req[%0d]: got req=%b addr=%h want req=1 addr=%h", i, imem_req, imem_addr, exp_pc); end
            imem_gnt = 1'b1;
            tick();
            imem_gnt = 1'b0;
            n_checks++; if (imem_req !== 1'b0 || if_valid !== 1'b0) begin n_fail++; $display("FAIL seq_wait[%0d]: got req=%b vld=%b want 0 0", i, imem_req, if_valid); end
            imem_rvalid = 1'b1;
            imem_rdata  = word;
            tick();
            imem_rvalid = 1'b0;
            n_checks++; if (if_valid !== 1'b1 || if_pc !== exp_pc || if_pc4 !== exp_pc + 32'd4 || if_instr !== word) begin n_fail++; $display("FAIL seq_hold[%0d]: got vld=%b pc=%h pc4=%h instr=%h want 1 %h %h %h", i, if_valid, if_pc, if_pc4, if_instr, exp_pc, exp_pc + 32'd4, word); end
            tick();
            n_checks++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL seq_consumed[%0d]: got vld=%b want 0", i, if_valid); end
        end
    endtask

    task automatic test_stall();
        apply_reset();
        tick();
        imem_gnt = 1'b1; tick(); imem_gnt = 1'b0;
        imem_rvalid = 1'b1; imem_rdata = 32'h1111_0000; tick(); imem_rvalid = 1'b0;
        tick();
        n_checks++; if (imem_addr !== 32'h3004) begin n_fail++; $display("FAIL stall_pre_addr: got %h want 00003004", imem_addr); end
        imem_gnt = 1'b1; tick(); imem_gnt = 1'b0;
        imem_rvalid = 1'b1; imem_rdata = 32'h2222_0004; stall = 1'b1; tick(); imem_rvalid = 1'b0;
        for (int unsigned k = 0; k < 4; k++) begin
            n_checks++; if (if_valid !== 1'b1 || if_pc !== 32'h3004 || if_pc4 !== 32'h3008 || if_instr !== 32'h2222_0004 || imem_req !== 1'b0) begin n_fail++; $display("FAIL stall_frozen[%0d]: got vld=%b pc=%h pc4=%h instr=%h req=%b want 1 00003004 00003008 22220004 0", k, if_valid, if_pc, if_pc4, if_instr, imem_req); end
            tick();
        end
        stall = 1'b0;
        n_checks++; if (if_valid !== 1'b1 || if_pc !== 32'h3004) begin n_fail++; $display("FAIL stall_still_held: got vld=%b pc=%h want 1 00003004", if_valid, if_pc); end
        tick();
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h3008 || if_valid !== 1'b0) begin n_fail++; $display("FAIL stall_release: got req=%b addr=%h vld=%b want 1 00003008 0", imem_req, imem_addr, if_valid); end
    endtask

    task automatic test_redirect_wait();
        apply_reset();
        tick();
        imem_gnt = 1'b1; tick(); imem_gnt = 1'b0;
        redirect_valid = 1'b1; redirect_pc = 32'h3100; tick(); redirect_valid = 1'b0;
        tick();
        imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF; tick(); imem_rvalid = 1'b0;
        n_checks++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL rdw_dropped: got vld=%b want 0", if_valid); end
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h3100) begin n_fail++; $display("FAIL rdw_addr: got req=%b addr=%h want 1 00003100", imem_req, imem_addr); end
        imem_gnt = 1'b1; tick(); imem_gnt = 1'b0;
        imem_rvalid = 1'b1; imem_rdata = 32'h3100_AAAA; tick(); imem_rvalid = 1'b0;
        n_checks++; if (if_valid !== 1'b1 || if_pc !== 32'h3100 || if_instr !== 32'h3100_AAAA) begin n_fail++; $display("FAIL rdw_resume: got vld=%b pc=%h instr=%h want 1 00003100 3100aaaa", if_valid, if_pc, if_instr); end
        tick();
        n_checks++; if (imem_addr !== 32'h3104) begin n_fail++; $display("FAIL rdw_next: got %h want 00003104", imem_addr); end
        imem_gnt = 1'b1; tick(); imem_gnt = 1'b0;
        imem_rvalid = 1'b1; imem_rdata = 32'hBAD0_BAD0;
        redirect_valid = 1'b1; redirect_pc = 32'h3180;
        tick();
        imem_rvalid = 1'b0; redirect_valid = 1'b0;
        n_checks++; if (if_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h3180) begin n_fail++; $display("FAIL rdw_same_cycle: got vld=%b req=%b addr=%h want 0 1 00003180", if_valid, imem_req, imem_addr); end
    endtask

    task automatic test_redirect_hold();
        apply_reset();
        tick();
        stall = 1'b1;
        imem_gnt = 1'b1; tick(); imem_gnt = 1'b0;
        imem_rvalid = 1'b1; imem_rdata = 32'h0BAD_F00D; tick(); imem_rvalid = 1'b0;
        n_checks++; if (if_valid !== 1'b1) begin n_fail++; $display("FAIL rdh_hold: got vld=%b want 1", if_valid); end
        redirect_valid = 1'b1; redirect_pc = 32'h3200; tick(); redirect_valid = 1'b0;
        n_checks++; if (if_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h3200) begin n_fail++; $display("FAIL rdh_redirect: got vld=%b req=%b addr=%h want 0 1 00003200", if_valid, imem_req, imem_addr); end
        stall = 1'b0;
    endtask

    task automatic test_no_grant();
        apply_reset();
        tick();
        for (int unsigned c = 0; c < 5; c++) begin
            if (c == 2) begin
                redirect_valid = 1'b1; redirect_pc = 32'h3300;
            end
            n_checks++; if (imem_req !== 1'b1 || imem_addr !== ((c <= 2) ? 32'h3000 : 32'h3300)) begin n_fail++; $display("FAIL nogrant[%0d]: got req=%b addr=%h want 1 %h", c, imem_req, imem_addr, (c <= 2) ? 32'h3000 : 32'h3300); end
            tick();
            redirect_valid = 1'b0;
        end
        imem_gnt = 1'b1; tick(); imem_gnt = 1'b0;
        n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL nogrant_wait: got req=%b want 0", imem_req); end
        imem_rvalid = 1'b1; imem_rdata = 32'h3300_0001; tick(); imem_rvalid = 1'b0;
        n_checks++; if (if_valid !== 1'b1 || if_pc !== 32'h3300) begin n_fail++; $display("FAIL nogrant_fetch: got vld=%b pc=%h want 1 00003300", if_valid, if_pc); end
    endtask

    task automatic test_wrap();
        apply_reset();
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC; tick(); redirect_valid = 1'b0;
        n_checks++; if (imem_addr !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_addr: got %h want fffffffc", imem_addr); end
        imem_gnt = 1'b1; tick(); imem_gnt = 1'b0;
        imem_rvalid = 1'b1; imem_rdata = 32'h0000_0013; tick(); imem_rvalid = 1'b0;
        n_checks++; if (if_pc !== 32'hFFFF_FFFC || if_pc4 !== 32'h0) begin n_fail++; $display("FAIL wrap_pc4: got pc=%h pc4=%h want fffffffc 00000000", if_pc, if_pc4); end
        tick();
        n_checks++; if (imem_addr !== 32'h0 || imem_req !== 1'b1 || fetch_err !== 1'b0) begin n_fail++; $display("FAIL wrap_next: got addr=%h req=%b err=%b want 0 1 0", imem_addr, imem_req, fetch_err); end
    endtask

    task automatic test_errors();
        apply_reset();
        tick();
        imem_gnt = 1'b1; tick(); imem_gnt = 1'b0;
        repeat (254) tick();
        n_checks++; if (fetch_err !== 1'b0 || imem_req !== 1'b0) begin n_fail++; $display("FAIL wdog_early: got err=%b req=%b want 0 0", fetch_err, imem_req); end
        tick();
        n_checks++; if (fetch_err !== 1'b1 || imem_req !== 1'b0 || if_valid !== 1'b0) begin n_fail++; $display("FAIL wdog_expire: got err=%b req=%b vld=%b want 1 0 0", fetch_err, imem_req, if_valid); end
        imem_gnt = 1'b1; imem_rvalid = 1'b1;
        redirect_valid = 1'b1; redirect_pc = 32'h3400;
        repeat (3) tick();
        imem_gnt = 1'b0; imem_rvalid = 1'b0; redirect_valid = 1'b0;
        n_checks++; if (fetch_err !== 1'b1 || imem_req !== 1'b0 || if_valid !== 1'b0) begin n_fail++; $display("FAIL wdog_sticky: got err=%b req=%b vld=%b want 1 0 0", fetch_err, imem_req, if_valid); end

        apply_reset();
        n_checks++; if (fetch_err !== 1'b0) begin n_fail++; $display("FAIL err_cleared: got %b want 0", fetch_err); end
        tick();
        redirect_valid = 1'b1; redirect_pc = 32'h3102;
        #1;
        n_checks++; if (fetch_err !== 1'b0) begin n_fail++; $display("FAIL misalign_pre: got %b want 0", fetch_err); end
        tick();
        redirect_valid = 1'b0;
        n_checks++; if (fetch_err !== 1'b1 || imem_req !== 1'b0) begin n_fail++; $display("FAIL misalign: got err=%b req=%b want 1 0", fetch_err, imem_req); end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_redirect_wait();
        test_redirect_hold();
        test_no_grant();
        test_wrap();
        test_errors();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
